// File: rtl/t03_sprite_pkg.sv
// Shared types and constants for the player sprite generator.
//   player_state_t : animation FSM states
//   POSE_*         : bitmap pose indices fed to the sprite ROM
//   TRANSPARENT    : colour value meaning "no sprite pixel here"
//   pose_of()      : maps FSM state + walk frame to a ROM pose index
package t03_sprite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    ATTACK = 2'd2
  } player_state_t;

  localparam logic [2:0] POSE_IDLE   = 3'd0;
  localparam logic [2:0] POSE_WALK0  = 3'd1;  // walk frames occupy 1..4
  localparam logic [2:0] POSE_ATTACK = 3'd5;

  localparam logic [7:0] TRANSPARENT = 8'd0;

  function automatic logic [2:0] pose_of(input player_state_t s, input logic [1:0] wf);
    case (s)
      WALK:    return POSE_WALK0 + {1'b0, wf};
      ATTACK:  return POSE_ATTACK;
      default: return POSE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/t03_player_sprite_rom.sv
// 1-bit sprite mask ROM: 6 poses of 16x16, purely combinational.
//   pose    [2:0] : pose index 0..5 (others read as empty)
//   row     [3:0] : bitmap row, 0 = top
//   col     [3:0] : bitmap column, 0 = left
//   pix_bit       : 1 = opaque body pixel
// Each row word stores column 0 in its MSB. Row 0 is an asymmetric marker
// shared by all poses (makes mirroring visible) and row 15 is a per-pose tag
// with a single bit at column <pose>, so the pose is readable off-screen.
module t03_player_sprite_rom (
  input  logic [2:0] pose,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       pix_bit
);

  localparam logic [0:15][15:0] P_IDLE = {
    16'hF0F0, 16'h07E0, 16'h0FF0, 16'h0DB0, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h1FF8,
    16'h3FFC, 16'h37EC, 16'h37EC, 16'h07E0, 16'h0660, 16'h0660, 16'h0E70, 16'h8000};
  localparam logic [0:15][15:0] P_WALK0 = {
    16'hF0F0, 16'h07E0, 16'h0FF0, 16'h0DB0, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0FF0,
    16'h1FF8, 16'h1BD8, 16'h03C0, 16'h07E0, 16'h0E70, 16'h1C38, 16'h1818, 16'h4000};
  localparam logic [0:15][15:0] P_WALK1 = {
    16'hF0F0, 16'h07E0, 16'h0FF0, 16'h0DB0, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0FF0,
    16'h1FF8, 16'h1BD8, 16'h03C0, 16'h03C0, 16'h07E0, 16'h0660, 16'h0660, 16'h2000};
  localparam logic [0:15][15:0] P_WALK2 = {
    16'hF0F0, 16'h07E0, 16'h0FF0, 16'h0DB0, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0FF0,
    16'h1FF8, 16'h1BD8, 16'h03C0, 16'h07E0, 16'h0E70, 16'h0C30, 16'h1C38, 16'h1000};
  localparam logic [0:15][15:0] P_WALK3 = {
    16'hF0F0, 16'h07E0, 16'h0FF0, 16'h0DB0, 16'h0FF0, 16'h07E0, 16'h03C0, 16'h0FF0,
    16'h1FF8, 16'h1BD8, 16'h03C0, 16'h03C0, 16'h03C0, 16'h07E0, 16'h0660, 16'h0800};
  localparam logic [0:15][15:0] P_ATK = {
    16'hF0F0, 16'h07E0, 16'h0FF0, 16'h0DB0, 16'h0FF0, 16'h07E0, 16'h03C7, 16'h0FFE,
    16'h1FFC, 16'h1BC0, 16'h03C0, 16'h07E0, 16'h0E70, 16'h1C38, 16'h1818, 16'h0400};

  logic [15:0] row_bits;

  always_comb begin
    row_bits = '0;
    case (pose)
      3'd0:    row_bits = P_IDLE[row];
      3'd1:    row_bits = P_WALK0[row];
      3'd2:    row_bits = P_WALK1[row];
      3'd3:    row_bits = P_WALK2[row];
      3'd4:    row_bits = P_WALK3[row];
      3'd5:    row_bits = P_ATK[row];
      default: row_bits = '0;
    endcase
  end

  assign pix_bit = row_bits[4'd15 - col];

endmodule

// File: rtl/t03_player_sprite_gen.sv
// Per-player sprite pixel generator feeding the colour mixer.
// Latches position/pose once per frame (Hcnt==0, Vcnt==V_LATCH), steps an
// IDLE/WALK/ATTACK animation FSM on that event, and emits one registered
// 8-bit pixel per clock (0 = transparent), one cycle after the beam position.
//   clk, rst          : clock, synchronous active-high reset
//   Hcnt, Vcnt        : beam position
//   pos_x, pos_y      : sprite top-left (sampled at the latch event)
//   facing_left       : mirror the bitmap horizontally
//   moving            : player walking this frame
//   attack_req        : one-cycle attack request, held until the next latch
//   body_color        : colour for opaque bitmap bits
//   sprite_pixel      : registered pixel colour
//   attack_active     : high while the FSM is in ATTACK
//   frame_tick        : one-cycle pulse after the latch cycle
module t03_player_sprite_gen
  import t03_sprite_pkg::*;
#(
  parameter int SPRITE_W      = 16,  // ROM is built for 16
  parameter int SCALE_SHIFT   = 1,
  parameter int ANIM_DIV      = 8,   // up to 256
  parameter int ATTACK_FRAMES = 12,  // up to 256
  parameter int V_LATCH       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] Hcnt,
  input  logic [10:0] Vcnt,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic        facing_left,
  input  logic        moving,
  input  logic        attack_req,
  input  logic [7:0]  body_color,
  output logic [7:0]  sprite_pixel,
  output logic        attack_active,
  output logic        frame_tick
);

  localparam int         BOX       = SPRITE_W << SCALE_SHIFT;
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);
  localparam logic [7:0] ATK_INIT  = 8'(ATTACK_FRAMES - 1);

  logic [10:0]   x_l_q, x_l_d, y_l_q, y_l_d;
  logic          face_l_q, face_l_d, mov_l_q, mov_l_d;
  logic          valid_q, valid_d, pending_q, pending_d;
  player_state_t state_q, state_d;
  logic [1:0]    walk_frame_q, walk_frame_d;
  logic [7:0]    anim_cnt_q, anim_cnt_d, atk_cnt_q, atk_cnt_d;
  logic [7:0]    sprite_pixel_q, sprite_pixel_d;
  logic          attack_active_q, attack_active_d, frame_tick_q, frame_tick_d;

  logic          latch;
  logic [10:0]   dx, dy;
  logic          in_x, in_y;
  logic [3:0]    col, row;
  logic          rom_bit;

  assign latch = (Hcnt == 11'd0) && (Vcnt == 11'(V_LATCH));

  // Latch registers, pending flag and animation FSM
  always_comb begin
    x_l_d        = x_l_q;
    y_l_d        = y_l_q;
    face_l_d     = face_l_q;
    mov_l_d      = mov_l_q;
    valid_d      = valid_q;
    state_d      = state_q;
    walk_frame_d = walk_frame_q;
    anim_cnt_d   = anim_cnt_q;
    atk_cnt_d    = atk_cnt_q;
    // Requests that arrive while attacking are dropped, not queued.
    pending_d    = pending_q | (attack_req && (state_q != ATTACK));

    if (latch) begin
      x_l_d    = pos_x;
      y_l_d    = pos_y;
      face_l_d = facing_left;
      mov_l_d  = moving;
      valid_d  = 1'b1;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_d   = ATTACK;
            atk_cnt_d = ATK_INIT;
            pending_d = 1'b0;
          end else if (mov_l_d) begin
            state_d = WALK;
          end
        end
        WALK: begin
          if (pending_q) begin
            state_d   = ATTACK;
            atk_cnt_d = ATK_INIT;
            pending_d = 1'b0;
          end else if (!mov_l_d) begin
            state_d      = IDLE;
            walk_frame_d = 2'd0;
            anim_cnt_d   = 8'd0;
          end else if (anim_cnt_q == ANIM_LAST) begin
            anim_cnt_d   = 8'd0;
            walk_frame_d = walk_frame_q + 2'd1;
          end else begin
            anim_cnt_d = anim_cnt_q + 8'd1;
          end
        end
        ATTACK: begin
          if (atk_cnt_q == 8'd0) begin
            state_d = mov_l_d ? WALK : IDLE;
            // Returning to IDLE restarts the walk cycle from its first frame.
            if (!mov_l_d) begin
              walk_frame_d = 2'd0;
              anim_cnt_d   = 8'd0;
            end
          end else begin
            atk_cnt_d = atk_cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Hit test. With Hcnt >= x_l the difference is exact, so dx < BOX is the
  // same as Hcnt < x_l + BOX evaluated wide: a box past 2047 clips, never wraps.
  always_comb begin
    dx   = Hcnt - x_l_q;
    dy   = Vcnt - y_l_q;
    in_x = (Hcnt >= x_l_q) && (dx < 11'(BOX));
    in_y = (Vcnt >= y_l_q) && (dy < 11'(BOX));
    col  = face_l_q ? (4'(SPRITE_W - 1) - dx[SCALE_SHIFT +: 4]) : dx[SCALE_SHIFT +: 4];
    row  = dy[SCALE_SHIFT +: 4];
  end

  t03_player_sprite_rom u_rom (
    .pose    (pose_of(state_q, walk_frame_q)),
    .row     (row),
    .col     (col),
    .pix_bit (rom_bit)
  );

  always_comb begin
    sprite_pixel_d  = (valid_q && in_x && in_y && rom_bit) ? body_color : TRANSPARENT;
    attack_active_d = (state_d == ATTACK);  // tracks state_q cycle for cycle
    frame_tick_d    = latch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_l_q           <= '0;
      y_l_q           <= '0;
      face_l_q        <= 1'b0;
      mov_l_q         <= 1'b0;
      valid_q         <= 1'b0;
      pending_q       <= 1'b0;
      state_q         <= IDLE;
      walk_frame_q    <= 2'd0;
      anim_cnt_q      <= 8'd0;
      atk_cnt_q       <= 8'd0;
      sprite_pixel_q  <= TRANSPARENT;
      attack_active_q <= 1'b0;
      frame_tick_q    <= 1'b0;
    end else begin
      x_l_q           <= x_l_d;
      y_l_q           <= y_l_d;
      face_l_q        <= face_l_d;
      mov_l_q         <= mov_l_d;
      valid_q         <= valid_d;
      pending_q       <= pending_d;
      state_q         <= state_d;
      walk_frame_q    <= walk_frame_d;
      anim_cnt_q      <= anim_cnt_d;
      atk_cnt_q       <= atk_cnt_d;
      sprite_pixel_q  <= sprite_pixel_d;
      attack_active_q <= attack_active_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign sprite_pixel  = sprite_pixel_q;
  assign attack_active = attack_active_q;
  assign frame_tick    = frame_tick_q;

endmodule
